alu_mdu: RTL

Parametrised multi-cycle execute unit for the risk-five core. It combines the single-cycle integer ALU operations with an iterative RV32M/RV64M multiply/divide unit behind one valid/ready handshake. It sits in the execute stage between the operand muxes and writeback, and stalls the control FSM through `in_ready`/`out_valid` while an M-extension operation iterates.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/mdu_iter.sv | 94 +++++++++
 rtl/alu_mdu.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and class helpers for the execute unit.
package alu_pkg;

  typedef enum logic [4:0] {
    F_ADD     = 5'd0,
    F_SUB     = 5'd1,
    F_SLL     = 5'd2,
    F_SLT     = 5'd3,
    F_SLTU    = 5'd4,
    F_XOR     = 5'd5,
    F_SRL     = 5'd6,
    F_SRA     = 5'd7,
    F_OR      = 5'd8,
    F_AND     = 5'd9,
    F_PASS_B  = 5'd10,
    F_MUL     = 5'd11,
    F_MULH    = 5'd12,
    F_MULHSU  = 5'd13,
    F_MULHU   = 5'd14,
    F_DIV     = 5'd15,
    F_DIVU    = 5'd16,
    F_REM     = 5'd17,
    F_REMU    = 5'd18,
    F_ILLEGAL = 5'd19   // first code of the 19..31 range that yields 0
  } func_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic is_iter(input logic [4:0] f);
    return (f >= F_MUL) && (f <= F_REMU);
  endfunction

  function automatic logic is_div(input logic [4:0] f);
    return (f >= F_DIV) && (f <= F_REMU);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: one product or quotient bit per cycle.
// The result is formed from the accumulator value being written on the final
// step, so the owner can capture it on the same edge the last bit lands.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN + 1);

  logic [2*XLEN-1:0] acc, acc_mul, acc_div, acc_nxt, prod;
  logic [XLEN-1:0]   opnd, ma, mb, div_sel, div_res, mul_res, diff;
  logic [XLEN:0]     sum, shifted;
  logic [CW-1:0]     cnt;
  logic              busy, div_q, hi_q, neg_q;
  logic              sa, sb, a_neg, b_neg, op_div, op_hi, neg_d, ge;

  // Operand signedness, magnitudes and result-sign decode at start.
  always_comb begin
    sa     = op inside {F_MUL, F_MULH, F_MULHSU, F_DIV, F_REM};
    sb     = op inside {F_MUL, F_MULH, F_DIV, F_REM};
    a_neg  = sa & a[XLEN-1];
    b_neg  = sb & b[XLEN-1];
    ma     = a_neg ? -a : a;
    mb     = b_neg ? -b : b;
    op_div = is_div(op);
    op_hi  = op_div ? (op inside {F_REM, F_REMU}) : (op != F_MUL);
    // remainder follows the dividend, everything else is sign(A) ^ sign(B)
    neg_d  = (op inside {F_REM, F_REMU}) ? a_neg : (a_neg ^ b_neg);
  end

  // One shift-add (multiply) or restoring-subtract (divide) step.
  always_comb begin
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    acc_mul = {sum, acc[XLEN-1:1]};
    shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    ge      = shifted >= {1'b0, opnd};
    diff    = shifted[XLEN-1:0] - opnd;
    acc_div = ge ? {diff, acc[XLEN-2:0], 1'b1}
                 : {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    acc_nxt = div_q ? acc_div : acc_mul;
  end

  // Sign fix-up and half selection on the post-step accumulator.
  always_comb begin
    prod    = neg_q ? -acc_nxt : acc_nxt;
    mul_res = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    div_sel = hi_q ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
    div_res = neg_q ? -div_sel : div_sel;
    res     = div_q ? div_res : mul_res;
  end

  assign done = busy && (cnt == CW'(1));

  // Operand load, iteration and down-counter with terminal count of 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      opnd  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      div_q <= 1'b0;
      hi_q  <= 1'b0;
      neg_q <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= CW'(XLEN);
      div_q <= op_div;
      hi_q  <= op_hi;
      neg_q <= neg_d;
      acc   <= op_div ? {{XLEN{1'b0}}, ma} : {{XLEN{1'b0}}, mb};
      opnd  <= op_div ? mb : ma;
    end else if (busy) begin
      acc <= acc_nxt;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute unit: single-cycle ALU plus iterative MUL/DIV behind valid/ready.
//
// state  | meaning
// -------+-------------------------------------------------
// S_IDLE | ready for a request (in_ready = 1)
// S_MUL  | multiply iterating in mdu_iter
// S_DIV  | divide iterating in mdu_iter
// S_DONE | result held, out_valid = 1 until out_ready
module alu_mdu
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      func,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            eq,
  output logic            a_lt_b,
  output logic            a_lt_ub
);

  state_e          state, state_d;
  logic [XLEN-1:0] alu_res, spec_res, mdu_res;
  logic [SHW-1:0]  shamt;
  logic            accept, special, go_iter, mdu_start, mdu_done;
  logic            div_b0, div_ovf;

  assign eq      = (A == B);
  assign a_lt_b  = $signed(A) < $signed(B);
  assign a_lt_ub = A < B;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  assign accept    = in_valid && in_ready && !flush;
  assign div_b0    = (B == '0);
  assign div_ovf   = (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
  assign special   = is_div(func) &&
                     (div_b0 || (div_ovf && (func == F_DIV || func == F_REM)));
  assign go_iter   = is_iter(func) && !special;
  assign mdu_start = accept && go_iter;

  // Single-cycle ALU on the live operands (captured at acceptance).
  always_comb begin
    shamt   = B[SHW-1:0];
    alu_res = '0;
    case (func)
      F_ADD:    alu_res = A + B;
      F_SUB:    alu_res = A - B;
      F_SLL:    alu_res = A << shamt;
      F_SLT:    alu_res = {{(XLEN-1){1'b0}}, a_lt_b};
      F_SLTU:   alu_res = {{(XLEN-1){1'b0}}, a_lt_ub};
      F_XOR:    alu_res = A ^ B;
      F_SRL:    alu_res = A >> shamt;
      F_SRA:    alu_res = $signed(A) >>> shamt;
      F_OR:     alu_res = A | B;
      F_AND:    alu_res = A & B;
      F_PASS_B: alu_res = B;
      default:  alu_res = '0;
    endcase
  end

  // Divide-by-zero and signed-overflow results that skip iteration.
  always_comb begin
    spec_res = '0;
    if (div_b0) spec_res = (func inside {F_DIV, F_DIVU}) ? '1 : A;
    else        spec_res = (func == F_DIV) ? A : '0;
  end

  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mdu_start),
    .abort (flush),
    .op    (func),
    .a     (A),
    .b     (B),
    .done  (mdu_done),
    .res   (mdu_res)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next-state decode; flush overrides everything.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (accept) begin
        if (go_iter) state_d = is_div(func) ? S_DIV : S_MUL;
        else         state_d = S_DONE;
      end
      S_MUL, S_DIV: if (mdu_done) state_d = S_DONE;
      S_DONE:       if (out_ready) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Result register: direct results at acceptance, MDU result on its last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else if (accept && !go_iter) begin
      result <= special ? spec_res : alu_res;
    end else if ((state == S_MUL || state == S_DIV) && mdu_done && !flush) begin
      result <= mdu_res;
    end
  end

endmodule
